// File: rtl/bit_fifo_pkg.sv
// Shared definitions for the bit_fifo family: default widths, the width
// helper used to derive count widths, and the packer state encodings.
package bit_fifo_pkg;

    // Number of bits needed to represent values 0..value-1.
    function automatic int clog2_w(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam int DEF_FIFO_IF_W = 48;
    localparam int DEF_FIFO_W    = 192;
    localparam int DEF_OUT_W     = 32;

    // Count widths hold 0..N inclusive, hence the +1.
    localparam int DEF_ADD_W    = clog2_w(DEF_FIFO_W + 1);
    localparam int DEF_IF_ADD_W = clog2_w(DEF_FIFO_IF_W + 1);
    localparam int DEF_CNT_W    = clog2_w(DEF_OUT_W + 1);

    typedef logic [1:0] state_t;

    localparam state_t ST_FILL  = 2'd0;
    localparam state_t ST_OUT   = 2'd1;
    localparam state_t ST_FDONE = 2'd2;

endpackage

// File: rtl/bit_word_acc.sv
// Word accumulator: merges 'take' new bits from data above the bits already
// held, LSB-first, and tracks how many bits are held.
module bit_word_acc
    import bit_fifo_pkg::*;
#(
    parameter int FIFO_IF_W = DEF_FIFO_IF_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int IF_ADD_W  = DEF_IF_ADD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [IF_ADD_W-1:0]  take,
    input  logic [FIFO_IF_W-1:0] data,
    output logic [OUT_W-1:0]     acc,
    output logic [CNT_W-1:0]     acc_cnt
);

    logic [FIFO_IF_W-1:0]       masked;
    logic [FIFO_IF_W+OUT_W-1:0] shifted;

    // Keep only the requested bits and line them up above the held bits.
    always_comb begin
        masked = '0;
        for (int i = 0; i < FIFO_IF_W; i++) begin
            masked[i] = data[i] & (IF_ADD_W'(i) < take);
        end
        shifted = {{OUT_W{1'b0}}, masked} << acc_cnt;
    end

    // Accumulator register; clear empties it after a word is handed off.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else if (take != '0) begin
            acc     <= acc | shifted[OUT_W-1:0];
            acc_cnt <= acc_cnt + CNT_W'(take);
        end
    end

endmodule

// File: rtl/bit_word_packer.sv
// Drains bit_fifo into fixed OUT_W-bit words on a valid/ready port, with a
// flush that forces out a zero-padded partial word.
// Define BIT_WORD_PACKER_MSB_FIRST_EN to present words bit-reversed (oldest
// bit at OUT_W-1, partial words left-aligned).
module bit_word_packer
    import bit_fifo_pkg::*;
#(
    parameter int FIFO_IF_W = DEF_FIFO_IF_W,
    parameter int FIFO_W    = DEF_FIFO_W,
    parameter int ADD_W     = DEF_ADD_W,
    parameter int IF_ADD_W  = DEF_IF_ADD_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADD_W-1:0]     fifo_num_bits,
    input  logic [FIFO_IF_W-1:0] fifo_data_out,
    output logic                 fifo_rd,
    output logic [IF_ADD_W-1:0]  fifo_rd_num_bits,
    input  logic                 fifo_rd_error,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic [OUT_W-1:0]     word_data,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 word_last,
    output logic [CNT_W:0]       word_nbits,
    output logic                 rd_err_sticky
);

    localparam int MW = (ADD_W > CNT_W + 1) ? ADD_W : CNT_W + 1;

    if (OUT_W > FIFO_IF_W || OUT_W > FIFO_W) begin : g_cfg_check
        $error("bit_word_packer: OUT_W must not exceed FIFO_IF_W or FIFO_W");
    end

    state_t               state;
    state_t               state_nx;
    logic                 last_nx;
    logic                 flush_pend;
    logic [OUT_W-1:0]     acc;
    logic [CNT_W-1:0]     acc_cnt;
    logic [OUT_W-1:0]     ordered;
    logic                 acc_clear;
    logic [MW-1:0]        room;
    logic [MW-1:0]        avail;
    logic [MW-1:0]        take_w;
    logic [MW-1:0]        next_cnt;
    logic [MW-1:0]        left;
    logic [IF_ADD_W-1:0]  take;

    bit_word_acc #(
        .FIFO_IF_W (FIFO_IF_W),
        .OUT_W     (OUT_W),
        .CNT_W     (CNT_W),
        .IF_ADD_W  (IF_ADD_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .take    (take),
        .data    (fifo_data_out),
        .acc     (acc),
        .acc_cnt (acc_cnt)
    );

    // Read sizing: fill the word as far as the FIFO allows, never over-read.
    always_comb begin
        room     = MW'(OUT_W) - MW'(acc_cnt);
        avail    = MW'(fifo_num_bits);
        take_w   = '0;
        if (state == ST_FILL) begin
            take_w = (room < avail) ? room : avail;
        end
        take     = IF_ADD_W'(take_w);
        next_cnt = MW'(acc_cnt) + take_w;
        left     = avail - take_w;
    end

    // Output-side bit ordering of the held word.
    always_comb begin
        ordered = '0;
`ifdef BIT_WORD_PACKER_MSB_FIRST_EN
        for (int i = 0; i < OUT_W; i++) begin
            ordered[OUT_W-1-i] = acc[i];
        end
`else
        ordered = acc;
`endif
    end

    // Port outputs decoded from the current state.
    always_comb begin
        fifo_rd          = (take_w != '0);
        fifo_rd_num_bits = take;
        word_valid       = (state == ST_OUT);
        word_data        = word_valid ? ordered : '0;
        word_nbits       = word_valid ? (CNT_W+1)'(acc_cnt) : '0;
        flush_done       = (state == ST_FDONE);
        acc_clear        = word_valid && word_ready;
    end

    // Next-state logic: word completion, flush of a partial word, flush
    // with nothing held, and handshake release.
    always_comb begin
        state_nx = state;
        last_nx  = word_last;
        case (state)
            ST_FILL: begin
                if (next_cnt == MW'(OUT_W)) begin
                    state_nx = ST_OUT;
                    last_nx  = flush_pend && (left == '0);
                end else if (flush_pend && (avail == '0)) begin
                    if (acc_cnt != '0) begin
                        state_nx = ST_OUT;
                        last_nx  = 1'b1;
                    end else begin
                        state_nx = ST_FDONE;
                    end
                end
            end
            ST_OUT: begin
                if (word_ready) begin
                    state_nx = word_last ? ST_FDONE : ST_FILL;
                    last_nx  = 1'b0;
                end
            end
            ST_FDONE: begin
                state_nx = ST_FILL;
            end
            default: begin
                state_nx = ST_FILL;
                last_nx  = 1'b0;
            end
        endcase
    end

    // Control registers; a flush request arriving in FDONE is absorbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FILL;
            word_last     <= 1'b0;
            flush_pend    <= 1'b0;
            rd_err_sticky <= 1'b0;
        end else begin
            state         <= state_nx;
            word_last     <= last_nx;
            rd_err_sticky <= rd_err_sticky | fifo_rd_error;
            if (state == ST_FDONE) begin
                flush_pend <= 1'b0;
            end else if (flush_req) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule
